keccak_state_seq: RTL and testbench

Parametrised, sequenced successor to the masked Keccak state register. Holds the NSHARES-share 1600-bit Keccak state and manages one full sponge message:
- lane-serial absorb of masked message lanes into the rate portion;
- NROUNDS round write-backs from the external masked round logic;
- lane-serial squeeze of masked output lanes.

It sits between the message/output streaming interfaces and the masked chi/round datapath. Shares are never recombined inside this block.

---
 rtl/keccak_state_seq_if.sv | 40 ++++
 rtl/keccak_state_seq.sv | 161 ++++++++++++++++
 tb/tb_keccak_state_seq.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/keccak_state_seq_if.sv
// keccak_state_seq_if: bundles the message, round-write-back and squeeze
// signals of keccak_state_seq into one port.
//   master : the environment side (message source, round logic, output sink)
//   slave  : the state sequencer itself
// Ports (slave view):
//   start, abs_valid, abs_data, abs_last  in   message streaming
//   abs_ready                             out
//   round_en, state_di                    in   round write-back
//   state_qo, perm_active, round_idx      out
//   sqz_valid, sqz_data                   out  output streaming
//   sqz_ready                             in
//   busy                                  out  sequencer not idle
interface keccak_state_seq_if #(
  parameter int NSHARES = 4
);
  logic                      start;
  logic                      abs_valid;
  logic                      abs_ready;
  logic [NSHARES*64-1:0]     abs_data;
  logic                      abs_last;
  logic                      round_en;
  logic [NSHARES*1600-1:0]   state_di;
  logic [NSHARES*1600-1:0]   state_qo;
  logic                      perm_active;
  logic [4:0]                round_idx;
  logic                      sqz_valid;
  logic                      sqz_ready;
  logic [NSHARES*64-1:0]     sqz_data;
  logic                      busy;

  modport master (
    output start, abs_valid, abs_data, abs_last, round_en, state_di, sqz_ready,
    input  abs_ready, state_qo, perm_active, round_idx, sqz_valid, sqz_data, busy
  );

  modport slave (
    input  start, abs_valid, abs_data, abs_last, round_en, state_di, sqz_ready,
    output abs_ready, state_qo, perm_active, round_idx, sqz_valid, sqz_data, busy
  );
endinterface

// File: rtl/keccak_state_seq.sv
// keccak_state_seq: holds the NSHARES-share 1600-bit masked Keccak state and
// sequences one sponge message: lane-serial absorb into the rate lanes,
// NROUNDS write-backs from the external masked round logic, then lane-serial
// squeeze of OUT_LANES lanes. Shares are never combined here.
// Ports:
//   clk  in  clock, rising edge
//   rst  in  asynchronous active-high reset
//   bus  keccak_state_seq_if.slave (see interface header for signal list)
module keccak_state_seq #(
  parameter int NSHARES    = 4,
  parameter int RATE_LANES = 17,
  parameter int OUT_LANES  = 4,
  parameter int NROUNDS    = 24
) (
  input  logic              clk,
  input  logic              rst,
  keccak_state_seq_if.slave bus
);
  localparam int SW = 1600;
  localparam int LW = 64;
  localparam int W  = NSHARES * SW;

  typedef enum logic [1:0] {IDLE, ABSORB, PERMUTE, SQUEEZE} fsm_t;

  fsm_t              fsm_reg, fsm_next;
  logic [W-1:0]      state_reg, state_next;
  logic [4:0]        lane_cnt_reg, lane_cnt_next;
  logic [4:0]        round_cnt_reg, round_cnt_next;
  logic [4:0]        sqz_cnt_reg, sqz_cnt_next;
  logic              last_flag_reg, last_flag_next;

  logic [W-1:0]          absorbed;
  logic [NSHARES*LW-1:0] sqz_lanes;

  logic                  abs_ready;
  logic                  perm_active;
  logic                  sqz_valid;
  logic [NSHARES*LW-1:0] sqz_data;

  // Absorb candidate: only the addressed rate lane of each share takes the XOR;
  // capacity lanes are wired straight through.
  genvar gi, gj;
  generate
    for (gi = 0; gi < NSHARES; gi++) begin : g_sh
      for (gj = 0; gj < 25; gj++) begin : g_ln
        localparam int B = gi*SW + gj*LW;
        if (gj < RATE_LANES) begin : g_rate
          assign absorbed[B +: LW] = state_reg[B +: LW] ^
            ((lane_cnt_reg == 5'(gj)) ? bus.abs_data[gi*LW +: LW] : {LW{1'b0}});
        end else begin : g_cap
          assign absorbed[B +: LW] = state_reg[B +: LW];
        end
      end
      assign sqz_lanes[gi*LW +: LW] = state_reg[gi*SW + int'(sqz_cnt_reg)*LW +: LW];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_reg       <= IDLE;
      state_reg     <= '0;
      lane_cnt_reg  <= '0;
      round_cnt_reg <= '0;
      sqz_cnt_reg   <= '0;
      last_flag_reg <= 1'b0;
    end else begin
      fsm_reg       <= fsm_next;
      state_reg     <= state_next;
      lane_cnt_reg  <= lane_cnt_next;
      round_cnt_reg <= round_cnt_next;
      sqz_cnt_reg   <= sqz_cnt_next;
      last_flag_reg <= last_flag_next;
    end
  end

  always_comb begin
    fsm_next       = fsm_reg;
    state_next     = state_reg;
    lane_cnt_next  = lane_cnt_reg;
    round_cnt_next = round_cnt_reg;
    sqz_cnt_next   = sqz_cnt_reg;
    last_flag_next = last_flag_reg;
    abs_ready      = 1'b0;
    perm_active    = 1'b0;
    sqz_valid      = 1'b0;
    sqz_data       = '0;

    case (fsm_reg)
      IDLE: begin
        if (bus.start) begin
          state_next     = '0;
          lane_cnt_next  = '0;
          last_flag_next = 1'b0;
          round_cnt_next = '0;
          fsm_next       = ABSORB;
        end
      end

      ABSORB: begin
        abs_ready = 1'b1;
        if (bus.abs_valid) begin
          state_next = absorbed;
          if (bus.abs_last) begin
            // Short final block: padding already applied upstream.
            last_flag_next = 1'b1;
            lane_cnt_next  = '0;
            fsm_next       = PERMUTE;
          end else if (lane_cnt_reg == 5'(RATE_LANES - 1)) begin
            lane_cnt_next = '0;
            fsm_next      = PERMUTE;
          end else begin
            lane_cnt_next = lane_cnt_reg + 5'd1;
          end
        end
      end

      PERMUTE: begin
        perm_active = 1'b1;
        // No timeout: round_en low simply holds everything.
        if (bus.round_en) begin
          state_next = bus.state_di;
          if (round_cnt_reg == 5'(NROUNDS - 1)) begin
            round_cnt_next = '0;
            if (last_flag_reg) begin
              sqz_cnt_next = '0;
              fsm_next     = SQUEEZE;
            end else begin
              lane_cnt_next = '0;
              fsm_next      = ABSORB;
            end
          end else begin
            round_cnt_next = round_cnt_reg + 5'd1;
          end
        end
      end

      SQUEEZE: begin
        sqz_valid = 1'b1;
        sqz_data  = sqz_lanes;
        if (bus.sqz_ready) begin
          if (sqz_cnt_reg == 5'(OUT_LANES - 1)) begin
            sqz_cnt_next = '0;
            fsm_next     = IDLE;
          end else begin
            sqz_cnt_next = sqz_cnt_reg + 5'd1;
          end
        end
      end

      default: fsm_next = IDLE;
    endcase
  end

  assign bus.abs_ready   = abs_ready;
  assign bus.perm_active = perm_active;
  assign bus.sqz_valid   = sqz_valid;
  assign bus.sqz_data    = sqz_data;
  assign bus.state_qo    = state_reg;
  assign bus.round_idx   = round_cnt_reg;
  assign bus.busy        = (fsm_reg != IDLE);
endmodule

// File: tb/tb_keccak_state_seq.sv
// tb_keccak_state_seq: randomized bench for keccak_state_seq. A lane-array
// model of the sponge state is updated as stimulus is applied; expected
// squeeze lanes are queued when the final permutation completes and a
// separate monitor pops and compares them at each squeeze handshake.
module tb_keccak_state_seq;
  localparam int NSH = 4;
  localparam int RL  = 17;
  localparam int OL  = 4;
  localparam int NR  = 24;
  localparam int W   = NSH * 1600;
  localparam int DW  = NSH * 64;

  logic clk = 1'b0;
  logic rst = 1'b0;

  keccak_state_seq_if #(.NSHARES(NSH)) bus ();

  keccak_state_seq #(
    .NSHARES(NSH), .RATE_LANES(RL), .OUT_LANES(OL), .NROUNDS(NR)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  logic [63:0]   mdl [NSH][25];
  bit            mdl_last;
  logic [DW-1:0] exp_q [$];
  int            vecs   = 0;
  int            errs   = 0;
  int            hs_cnt = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_wide(string nm, logic [DW-1:0] act, logic [DW-1:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_state(string nm);
    int bs = -1;
    int bk = -1;
    for (int s = 0; s < NSH; s++)
      for (int k = 0; k < 25; k++)
        if (bs < 0 && bus.state_qo[s*1600 + k*64 +: 64] !== mdl[s][k]) begin
          bs = s;
          bk = k;
        end
    vecs++;
    if (bs >= 0) begin
      errs++;
      $display("FAIL %s: share %0d lane %0d got %h expected %h", nm, bs, bk,
               bus.state_qo[bs*1600 + bk*64 +: 64], mdl[bs][bk]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] rnd_state();
    logic [W-1:0] r;
    for (int i = 0; i < W/32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [DW-1:0] rnd_lane();
    logic [DW-1:0] r;
    for (int i = 0; i < DW/32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic mdl_zero();
    for (int s = 0; s < NSH; s++)
      for (int k = 0; k < 25; k++) mdl[s][k] = '0;
    mdl_last = 1'b0;
  endtask

  // Monitor: compares every squeeze handshake against the scoreboard and
  // checks that presented data holds while the sink stalls.
  logic [DW-1:0] held_data;
  bit            held_stall = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      held_stall = 1'b0;
    end else begin
      if (held_stall) chk_wide("sqz_hold", bus.sqz_data, held_data);
      if (bus.sqz_valid && bus.sqz_ready) begin
        hs_cnt++;
        if (exp_q.size() == 0) begin
          vecs++;
          errs++;
          $display("FAIL sqz_unexpected: got %h expected no handshake", bus.sqz_data);
        end else begin
          chk_wide("sqz_data", bus.sqz_data, exp_q.pop_front());
        end
      end
      held_stall = bus.sqz_valid && !bus.sqz_ready;
      held_data  = bus.sqz_data;
    end
  end

  task automatic do_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    mdl_zero();
    chk("start_abs_ready", bus.abs_ready, 1);
    chk_state("start_zero");
  endtask

  task automatic absorb_lane(int k, logic [DW-1:0] d, bit last, bit poke_start);
    bit ok = 1'b0;
    bit r;
    if ($urandom_range(0, 3) == 0) tick();
    bus.abs_valid = 1'b1;
    bus.abs_data  = d;
    bus.abs_last  = last;
    bus.start     = poke_start;
    for (int i = 0; i < 50; i++) begin
      r = bus.abs_ready;
      tick();
      if (r) begin
        ok = 1'b1;
        break;
      end
    end
    bus.abs_valid = 1'b0;
    bus.abs_last  = 1'b0;
    bus.start     = 1'b0;
    chk("absorb_accept", ok, 1);
    for (int s = 0; s < NSH; s++) mdl[s][k] = mdl[s][k] ^ d[s*64 +: 64];
    if (last) mdl_last = 1'b1;
    if (last || k == RL-1) begin
      chk("absorb_perm_active", bus.perm_active, 1);
      chk("absorb_ready_drop", bus.abs_ready, 0);
    end else begin
      chk("absorb_ready_hold", bus.abs_ready, 1);
    end
  endtask

  // mode 0: every cycle, 1: pattern 1,0,0, 2: random gaps.
  task automatic do_rounds(int mode, bit use_c, logic [W-1:0] c, int nstop);
    int writes = 0;
    int cyc = 0;
    bit en;
    logic [W-1:0] di;
    while (writes < nstop && cyc < 2000) begin
      en = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
      di = use_c ? c : rnd_state();
      bus.round_en = en;
      bus.state_di = di;
      // A stray absorb during a stall must be ignored.
      bus.abs_valid = !en && ($urandom_range(0, 1) == 1);
      bus.abs_data  = rnd_lane();
      tick();
      cyc++;
      if (en) begin
        writes++;
        for (int s = 0; s < NSH; s++)
          for (int k = 0; k < 25; k++) mdl[s][k] = di[s*1600 + k*64 +: 64];
        if (writes < NR) begin
          chk("round_idx", bus.round_idx, writes);
          chk("perm_active_run", bus.perm_active, 1);
        end
      end else begin
        chk("round_idx_stall", bus.round_idx, writes);
      end
    end
    bus.round_en  = 1'b0;
    bus.abs_valid = 1'b0;
    chk("rounds_done", writes, nstop);
    if (nstop == NR) begin
      chk("round_idx_clear", bus.round_idx, 0);
      if (mdl_last) begin
        chk("perm_end_active", bus.perm_active, 0);
        chk("perm_end_sqz_valid", bus.sqz_valid, 1);
        for (int i = 0; i < OL; i++) begin
          logic [DW-1:0] e;
          for (int s = 0; s < NSH; s++) e[s*64 +: 64] = mdl[s][i];
          exp_q.push_back(e);
        end
      end else begin
        chk("perm_end_abs_ready", bus.abs_ready, 1);
      end
    end
    chk_state("perm_state");
  endtask

  // mode 0: sqz_ready toggles, 1: held high, 2: random.
  task automatic do_squeeze(int mode);
    int h0 = hs_cnt;
    bit ok = 1'b0;
    for (int c = 0; c < 300; c++) begin
      bus.sqz_ready = (mode == 0) ? 1'(c % 2) : (mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
      bus.round_en  = 1'($urandom_range(0, 1));
      bus.state_di  = rnd_state();
      tick();
      if (!bus.busy) begin
        ok = 1'b1;
        break;
      end
    end
    bus.sqz_ready = 1'b0;
    bus.round_en  = 1'b0;
    chk("squeeze_finish", ok, 1);
    chk("squeeze_handshakes", hs_cnt - h0, OL);
    chk("squeeze_queue_empty", exp_q.size(), 0);
    chk("squeeze_valid_low", bus.sqz_valid, 0);
    chk_state("squeeze_state_kept");
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [DW-1:0] d;
    logic [W-1:0]  cst;
    int            nblk, nl;

    bus.start     = 1'b0;
    bus.abs_valid = 1'b0;
    bus.abs_data  = '0;
    bus.abs_last  = 1'b0;
    bus.round_en  = 1'b0;
    bus.state_di  = '0;
    bus.sqz_ready = 1'b0;
    mdl_zero();

    // Asynchronous reset before any clock edge.
    #2 rst = 1'b1;
    #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_abs_ready", bus.abs_ready, 0);
    chk("rst_sqz_valid", bus.sqz_valid, 0);
    chk("rst_perm_active", bus.perm_active, 0);
    chk("rst_round_idx", bus.round_idx, 0);
    chk_wide("rst_sqz_data", bus.sqz_data, '0);
    chk_state("rst_state");
    tick();
    @(negedge clk) rst = 1'b0;
    tick();

    // Absorb XOR, stalled rounds, toggling squeeze backpressure.
    do_start();
    for (int k = 0; k < RL; k++) begin
      d = '0;
      d[63:0] = 64'(k + 1);
      absorb_lane(k, d, k == RL-1, k == 3);
    end
    chk_state("absorb_xor");
    do_rounds(1, 1'b0, '0, NR);
    do_squeeze(0);

    // Reset mid-permutation at round_idx 7.
    do_start();
    for (int k = 0; k < RL; k++) absorb_lane(k, rnd_lane(), 1'b0, 1'b0);
    do_rounds(0, 1'b0, '0, 7);
    chk("pre_rst_round_idx", bus.round_idx, 7);
    #2 rst = 1'b1;
    #1;
    mdl_zero();
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_perm_active", bus.perm_active, 0);
    chk("mid_rst_round_idx", bus.round_idx, 0);
    chk_state("mid_rst_state");
    @(negedge clk) rst = 1'b0;
    tick();
    do_start();
    for (int k = 0; k < RL; k++) absorb_lane(k, rnd_lane(), k == RL-1, 1'b0);
    do_rounds(0, 1'b0, '0, NR);
    do_squeeze(1);

    // Multi-block with a constant round result; start directly from the
    // IDLE cycle that follows the last squeeze handshake.
    do_start();
    for (int k = 0; k < RL; k++) absorb_lane(k, rnd_lane(), 1'b0, k == 5);
    cst = rnd_state();
    do_rounds(0, 1'b1, cst, NR);
    d = '0;
    d[63:0] = 64'hFF;
    absorb_lane(0, d, 1'b1, 1'b0);
    chk("multi_lane0", bus.state_qo[63:0], cst[63:0] ^ 64'hFF);
    chk_state("multi_absorb");
    do_rounds(2, 1'b0, '0, NR);
    do_squeeze(2);

    // Random messages.
    for (int m = 0; m < 3; m++) begin
      do_start();
      nblk = $urandom_range(1, 2);
      for (int b = 0; b < nblk; b++) begin
        nl = (b == nblk-1) ? $urandom_range(1, RL) : RL;
        for (int k = 0; k < nl; k++)
          absorb_lane(k, rnd_lane(), (b == nblk-1) && (k == nl-1), 1'b0);
        do_rounds(2, 1'b0, '0, NR);
      end
      do_squeeze(2);
    end

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
